// File: rtl/endian_byte_serializer.sv
// Serializes one register value as a byte stream in little- or big-endian order,
// using the byteswap ALUControl/imm encoding (4'hd = LE, 4'he = BE; imm = 16/32/64).
module endian_byte_serializer #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        ALUControl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] src_r, src_s;
  logic              be_r, be_s;
  logic [2:0]        last_idx_r, last_idx_s;
  logic [2:0]        k_r, k_s;
  logic              in_ready_r, in_ready_s;
  logic              out_valid_r, out_valid_s;
  logic [7:0]        out_byte_r, out_byte_s;
  logic              out_last_r, out_last_s;
  logic              err_r, err_s;

  logic              legal_s;
  logic [2:0]        req_last_s;
  logic [2:0]        next_k_s;

  // Byte idx of a word; idx never exceeds the captured width's last byte.
  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] v, input logic [2:0] idx);
    pick_byte = 8'(v >> {idx, 3'b000});
  endfunction

  // Request decode: legality and the index of the final byte (N-1).
  always_comb begin
    legal_s    = 1'b0;
    req_last_s = 3'd0;
    if ((ALUControl == 4'hd) || (ALUControl == 4'he)) begin
      if (imm == DATA_W'(16)) begin
        legal_s    = 1'b1;
        req_last_s = 3'd1;
      end else if (imm == DATA_W'(32)) begin
        legal_s    = 1'b1;
        req_last_s = 3'd3;
      end else if ((DATA_W == 64) && (imm == DATA_W'(64))) begin
        legal_s    = 1'b1;
        req_last_s = 3'd7;
      end else begin
        legal_s    = 1'b0;
        req_last_s = 3'd0;
      end
    end else begin
      legal_s    = 1'b0;
      req_last_s = 3'd0;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    src_s       = src_r;
    be_s        = be_r;
    last_idx_s  = last_idx_r;
    k_s         = k_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    out_byte_s  = out_byte_r;
    out_last_s  = out_last_r;
    err_s       = 1'b0;
    next_k_s    = k_r + 3'd1;
    case (state_r)
      IDLE: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        if (in_valid && in_ready_r) begin
          if (legal_s) begin
            state_s     = SEND;
            src_s       = src;
            be_s        = (ALUControl == 4'he);
            last_idx_s  = req_last_s;
            k_s         = 3'd0;
            in_ready_s  = 1'b0;
            out_valid_s = 1'b1;
            out_last_s  = 1'b0;
            out_byte_s  = pick_byte(src, (ALUControl == 4'he) ? req_last_s : 3'd0);
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        in_ready_s = 1'b0;
        if (out_ready) begin
          if (k_r == last_idx_r) begin
            // Final byte taken: one idle cycle before the next accept.
            state_s     = IDLE;
            k_s         = 3'd0;
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
            out_byte_s  = 8'h00;
            out_last_s  = 1'b0;
          end else begin
            k_s        = next_k_s;
            out_byte_s = pick_byte(src_r, be_r ? (last_idx_r - next_k_s) : next_k_s);
            out_last_s = (next_k_s == last_idx_r);
          end
        end else begin
          k_s = k_r;
        end
      end
      default: begin
        state_s     = IDLE;
        k_s         = 3'd0;
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        out_byte_s  = 8'h00;
        out_last_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      src_r       <= '0;
      be_r        <= 1'b0;
      last_idx_r  <= 3'd0;
      k_r         <= 3'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'h00;
      out_last_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      src_r       <= src_s;
      be_r        <= be_s;
      last_idx_r  <= last_idx_s;
      k_r         <= k_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_byte_r  <= out_byte_s;
      out_last_r  <= out_last_s;
      err_r       <= err_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_byte  = out_byte_r;
  assign out_last  = out_last_r;
  assign err       = err_r;

endmodule

// File: tb/tb_endian_byte_serializer.sv
// Directed bench for endian_byte_serializer: a 64-bit and a 32-bit instance,
// hand-computed byte streams, backpressure, illegal requests and mid-transfer reset.
module tb_endian_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        in_valid = 1'b0, in_ready;
  logic [63:0] src = 64'h0, imm = 64'h0;
  logic [3:0]  ctl = 4'h0;
  logic        out_valid, out_ready = 1'b1, out_last, err;
  logic [7:0]  out_byte;

  logic        in_valid32 = 1'b0, in_ready32;
  logic [31:0] src32 = 32'h0, imm32 = 32'h0;
  logic [3:0]  ctl32 = 4'h0;
  logic        out_valid32, out_ready32 = 1'b1, out_last32, err32;
  logic [7:0]  out_byte32;

  always #5 clk = ~clk;

  endian_byte_serializer #(.DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src(src), .imm(imm), .ALUControl(ctl), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last), .err(err)
  );

  endian_byte_serializer #(.DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .src(src32), .imm(imm32), .ALUControl(ctl32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_byte(out_byte32), .out_last(out_last32), .err(err32)
  );

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_byte, out_last, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset64: got rdy=%b vld=%b byte=%h last=%b err=%b, want 1 0 00 0 0",
               in_ready, out_valid, out_byte, out_last, err);
    end
    checks++;
    if ({in_ready32, out_valid32, out_byte32, out_last32, err32} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset32: got rdy=%b vld=%b byte=%h last=%b err=%b, want 1 0 00 0 0",
               in_ready32, out_valid32, out_byte32, out_last32, err32);
    end
    rst_n = 1'b1;
  endtask

  // Four conversions of the same source; expected bytes packed MSB-first.
  task automatic test_convert();
    logic [63:0] exp_v;
    logic [3:0]  c;
    logic [63:0] w;
    int          n;
    for (int v = 0; v < 4; v++) begin
      case (v)
        0:       begin c = 4'he; w = 64'd64; n = 8; exp_v = 64'h0123456789ABCDEF; end
        1:       begin c = 4'hd; w = 64'd16; n = 2; exp_v = 64'hEFCD000000000000; end
        2:       begin c = 4'hd; w = 64'd32; n = 4; exp_v = 64'hEFCDAB8900000000; end
        default: begin c = 4'he; w = 64'd32; n = 4; exp_v = 64'h89ABCDEF00000000; end
      endcase
      @(negedge clk);
      in_valid = 1'b1; src = 64'h0123456789ABCDEF; imm = w; ctl = c;
      @(posedge clk); #1;
      in_valid = 1'b0; src = 64'hFFFF_FFFF_FFFF_FFFF; imm = 64'd24; ctl = 4'h3;
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        checks++;
        if ({out_valid, out_byte, out_last, in_ready} !==
            {1'b1, exp_v[63-8*i -: 8], (i == n - 1), 1'b0}) begin
          errors++;
          $display("FAIL convert v%0d byte%0d: got vld=%b byte=%h last=%b rdy=%b, want 1 %h %b 0",
                   v, i, out_valid, out_byte, out_last, in_ready, exp_v[63-8*i -: 8], (i == n - 1));
        end
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL convert v%0d done: got vld=%b rdy=%b, want 0 1", v, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [0:7];
    logic       exp_l [0:7];
    exp_b = '{8'h89, 8'hAB, 8'hCD, 8'hCD, 8'hCD, 8'hCD, 8'hEF, 8'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    in_valid = 1'b1; src = 64'h0123456789ABCDEF; imm = 64'd32; ctl = 4'he;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_byte, out_last} !== {(i != 7), exp_b[i], exp_l[i]}) begin
        errors++;
        $display("FAIL backpressure cyc%0d: got vld=%b byte=%h last=%b, want %b %h %b",
                 i, out_valid, out_byte, out_last, (i != 7), exp_b[i], exp_l[i]);
      end
      if (i == 2) out_ready = 1'b0;
      if (i == 5) out_ready = 1'b1;
    end
  endtask

  // in_valid held high: a 2-byte request repeats every 3 cycles.
  task automatic test_back_to_back();
    logic [5:0] exp_vld = 6'b110110;
    logic [5:0] exp_lst = 6'b010010;
    @(negedge clk);
    in_valid = 1'b1; src = 64'h0000_0000_0000_1234; imm = 64'd16; ctl = 4'he;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_last} !== {exp_vld[5-i], exp_lst[5-i]}) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got vld=%b last=%b, want %b %b",
                 i, out_valid, out_last, exp_vld[5-i], exp_lst[5-i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      in_valid = 1'b1; src = 64'h0123456789ABCDEF;
      imm = (v == 0) ? 64'd24 : 64'd32;
      ctl = (v == 0) ? 4'he : 4'h3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({err, out_valid, in_ready} !== 3'b101) begin
        errors++;
        $display("FAIL illegal v%0d pulse: got err=%b vld=%b rdy=%b, want 1 0 1", v, err, out_valid, in_ready);
      end
      @(negedge clk);
      checks++;
      if ({err, out_valid, in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL illegal v%0d after: got err=%b vld=%b rdy=%b, want 0 0 1", v, err, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_w32_illegal();
    @(negedge clk);
    in_valid32 = 1'b1; src32 = 32'h89ABCDEF; imm32 = 32'd64; ctl32 = 4'he;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({err32, out_valid32, in_ready32} !== {(i == 0), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL w32_imm64 cyc%0d: got err=%b vld=%b rdy=%b, want %b 0 1",
                 i, err32, out_valid32, in_ready32, (i == 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; src = 64'h0123456789ABCDEF; imm = 64'd64; ctl = 4'he;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_byte} !== {1'b1, 8'h45}) begin
      errors++;
      $display("FAIL reset_mid third byte: got vld=%b byte=%h, want 1 45", out_valid, out_byte);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_byte, out_last} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid abort: got vld=%b rdy=%b byte=%h last=%b, want 0 1 00 0",
               out_valid, in_ready, out_byte, out_last);
    end
  endtask

  task automatic test_recovery();
    logic [7:0] exp_b [0:1];
    exp_b = '{8'hEF, 8'hBE};
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; src = 64'h0000_0000_0000_BEEF; imm = 64'd16; ctl = 4'hd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_byte, out_last} !== {1'b1, exp_b[i], (i == 1)}) begin
        errors++;
        $display("FAIL recovery byte%0d: got vld=%b byte=%h last=%b, want 1 %h %b",
                 i, out_valid, out_byte, out_last, exp_b[i], (i == 1));
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL recovery done: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_w32_illegal();
    test_reset_mid();
    test_recovery();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/endian_byte_serializer.md
Name: endian_byte_serializer

Overview:
- Transmit-side companion to the byteswap32/byteswap64 ALU units.
- Accepts one register value with an endian-conversion opcode and width (same ALUControl/imm encoding as the byteswap units).
- Emits the converted value as a byte stream, one byte per handshake, in the selected byte order.
- Sits between the register file and the byte-wide memory/packet write path.

Parameters:
- DATA_W, 64, source register width; legal values 32 or 64. With 32, imm=64 is illegal.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- src  input  DATA_W  value to serialize
- imm  input  DATA_W  conversion width in bits; legal 16, 32, 64
- ALUControl  input  4  4'hd = little-endian order, 4'he = big-endian order
- out_valid  output  1  out_byte valid
- out_ready  input  1  downstream accepts byte
- out_byte  output  8  current byte
- out_last  output  1  high with the final byte of a request
- err  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; out_byte=0; out_last=0; err=0.
  - Byte counter and captured src cleared.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1.
  - Accept on the rising edge with in_valid&in_ready. Capture src, ALUControl and N=imm/8 (2, 4 or 8). Clear counter k=0. Go to SEND.
  - Illegal request: imm not in {16,32,64}, imm=64 with DATA_W=32, or ALUControl not in {d,e}.
    - Accepted handshake, nothing captured, state stays IDLE.
    - err=1 for exactly the next cycle.
- SEND:
  - in_ready=0; out_valid=1, starting the cycle after accept (latency 1).
  - LE (4'hd): byte k = src[8k+7:8k].
  - BE (4'he): byte k = src[8(N-1-k)+7 : 8(N-1-k)].
  - Only the low imm bits of src are used; upper bits ignored.
  - out_last=1 iff k==N-1.
  - On out_valid&out_ready: k increments. On the last byte, go to IDLE; out_valid=0 and in_ready=1 the next cycle.
  - No input accept in the same cycle as the last byte.
  - Back-to-back requests therefore cost N+1 cycles each.
- Backpressure:
  - While out_valid&!out_ready, out_byte and out_last hold stable and k holds.
  - out_valid never drops before its byte is taken.
- src, imm and ALUControl changes after accept have no effect.
- Reset asserted mid-transfer:
  - Immediately abort, out_valid=0, no partial completion.
  - After rst_n deasserts, the first accept is the earliest edge with in_valid=1.
- Counter: 3 bits wide, never wraps past N-1.
- Registered outputs only; no combinational path from in_* to out_*.

Test Plan:
- src=64'h0123456789ABCDEF, ALUControl=e, imm=64, out_ready=1 -> bytes 01,23,45,67,89,AB,CD,EF on consecutive cycles, out_last only on EF, in_ready returns 1 the cycle after.
- Same src, ALUControl=d, imm=16 -> bytes EF,CD, out_last on CD.
- Same src, ALUControl=d, imm=32 -> EF,CD,AB,89.
- Same src, ALUControl=e, imm=32 -> 89,AB,CD,EF.
- Backpressure: BE imm=32; drop out_ready for 3 cycles after byte AB -> out_byte holds CD with out_valid=1 throughout, then CD,EF complete normally.
- imm=24 or ALUControl=4'h3 -> err pulses for 1 cycle, out_valid stays 0, in_ready stays 1.
- DATA_W=32 instance, imm=64 -> err pulses, no bytes.
- Reset mid-transfer: assert rst_n=0 during the 3rd byte of BE imm=64 -> out_valid=0 asynchronously, in_ready=1.
- Recovery after reset: a fresh LE imm=16 request on src=64'h00000000_0000BEEF -> EF,BE.
